signal_mux_arb: RTL and testbench
=================================

# signal_mux_arb

Parametrised, registered successor to the combinational signal-select mux in the detector readout path. Accepts NCH request-tagged data words (count, filter, science-frame sources, and others), buffers one word per channel, arbitrates among pending channels, and presents one word at a time on a valid/ready output with a channel tag. When nothing is pending, the output carries a registered default word, the sf_count-style frame counter. It sits between the per-signal counters and the FIFO/packetiser feeding the readout link.

## Interface
- WIDTH, 16, data word width
- NCH, 4, number of source channels (2..16); channel 0 has the highest fixed priority
- CHW, $clog2(NCH), channel tag width (derived)
- clk  in  1  system clock; all logic on the rising edge
- reset_n  in  1  synchronous, active-low reset
- req  in  NCH  per-channel single-cycle capture strobe
- data_in  in  NCH*WIDTH  flattened channel words; channel k occupies [k*WIDTH +: WIDTH]
- default_data  in  WIDTH  word presented while idle
- out_ready  in  1  downstream accepts out_data this cycle
- out_data  out  WIDTH  selected word (registered)
- out_valid  out  1  out_data holds a captured channel word
- out_ch  out  CHW  source channel of out_data
- overrun  out  NCH  sticky per-channel overwrite flags
- overrun_clr  in  1  clears all overrun bits

## Operation
- Capture stage: when req[k]=1, latch data_in[k] into slot k and set pend[k]=1.
- If req[k] arrives while pend[k]=1 and slot k is not being granted that cycle, overwrite the slot and set overrun[k].
- Grant condition: `load = (!out_valid || out_ready) && |pend`.
- Arbitration when load: pick one pending channel. Default is fixed priority, lowest index wins. Copy the slot to out_data, set out_ch, set out_valid=1, and clear pend[grant].
- Simultaneous req[k] and grant of k: grant the old slot contents; the new word is captured and pend[k] stays 1. This is not an overrun.
- If `out_valid && out_ready && !|pend`: out_valid→0 and out_data←default_data.
- While idle (out_valid=0, no load): out_data←default_data every cycle, out_ch←0.
- While `out_valid && !out_ready`: out_data and out_ch hold stable. This is a hard requirement.
- overrun_clr has priority over a same-cycle overrun set: the clear wins and the bit reads 0.
- Reset (reset_n=0 at an edge): pend=0, overrun=0, slots=0, out_valid=0, out_data=0, out_ch=0, RR pointer=0. A reset mid-transfer drops any held word without a handshake.

## Timing
- req at edge t → pend set after t → earliest out_valid after edge t+1. Minimum latency is 2 cycles.
- Back-to-back throughput with out_ready held at 1: one word per cycle.
- default_data reaches out_data one cycle after sampling, when idle.
- overrun asserts the cycle after the overwriting req.
- No combinational path from any input to any output.

## Configuration
- SIGNAL_MUX_ARB_RR_EN defined:
  - Round-robin arbitration. An rr_ptr register points one past the last granted channel; the search starts at rr_ptr and wraps at NCH-1→0.
  - rr_ptr updates only on load.
- SIGNAL_MUX_ARB_RR_EN undefined:
  - Fixed priority, channel 0 highest.
  - No rr_ptr register.

## Structure
- Package signal_mux_pkg holds:
  - MAX_NCH=16
  - a priority-encode function
  - a rotate-and-encode function for round robin
- One sub-module, signal_mux_arb_sel: combinational grant selector (pend, rr_ptr → grant index, any). It is the only place the macro is tested.
- The capture slots and output register stay in the top module.

## Test plan
- Reset: drive reset_n=0 with req=4'b1111 active. After release, out_valid=0, out_data=0, pend empty, overrun=0. Next cycle out_data=default_data (0x00AA).
- Fixed priority: req=4'b1010 in one cycle with data ch1=0x1111, ch3=0x3333, out_ready=1. Expect 0x1111/ch1 at t+2, then 0x3333/ch3 at t+3, then default_data.
- Backpressure: hold out_ready=0 for 5 cycles with ch0=0x0BEE pending. out_data=0x0BEE and out_ch=0 stay stable. Single accept when out_ready=1.
- Overrun: with out_ready=0, pulse req[2] twice (0x0002, then 0x0022). overrun[2]=1 and delivered word=0x0022. Pulse overrun_clr → 0.
- Simultaneous grant and capture: req[0] is being granted (old 0x0001) as a new req[0] arrives (0x0101). Expect 0x0001 then 0x0101. overrun[0]=0.
- SIGNAL_MUX_ARB_RR_EN: all 4 channels continuously re-requested, out_ready=1. Grant sequence is 0,1,2,3,0,… with each channel served once per 4 words.

Source files
------------

// File: rtl/signal_mux_pkg.sv
// Shared constants and grant-encoding helpers for the signal_mux_arb readout mux.
package signal_mux_pkg;

  localparam int MAX_NCH = 16;
  localparam int IDXW    = 4;

  // Lowest set bit wins; returns 0 when nothing is set.
  function automatic logic [IDXW-1:0] prio_enc(input logic [MAX_NCH-1:0] v);
    prio_enc = '0;
    for (int i = MAX_NCH - 1; i >= 0; i--) begin
      if (v[i]) prio_enc = IDXW'(i);
    end
  endfunction

  // First set bit at or after ptr, wrapping at nch-1 -> 0.
  function automatic logic [IDXW-1:0] rr_enc(input logic [MAX_NCH-1:0] v,
                                             input logic [IDXW-1:0]    ptr,
                                             input int                 nch);
    logic            found;
    logic [IDXW:0]   idx;
    rr_enc = '0;
    found  = 1'b0;
    for (int i = 0; i < MAX_NCH; i++) begin
      if (i < nch) begin
        idx = {1'b0, ptr} + (IDXW + 1)'(i);
        if (idx >= (IDXW + 1)'(nch)) idx = idx - (IDXW + 1)'(nch);
        if (!found && v[idx[IDXW-1:0]]) begin
          found  = 1'b1;
          rr_enc = idx[IDXW-1:0];
        end
      end
    end
  endfunction

endpackage

// File: rtl/signal_mux_arb_sel.sv
// Combinational grant selector: fixed priority by default, round robin when
// SIGNAL_MUX_ARB_RR_EN is defined.
module signal_mux_arb_sel
  import signal_mux_pkg::*;
#(
  parameter int NCH = 4,
  parameter int CHW = $clog2(NCH)
) (
  input  logic [NCH-1:0] pend,
  input  logic [CHW-1:0] rr_ptr,
  output logic [CHW-1:0] grant,
  output logic           any,
  output logic [CHW-1:0] ptr_next
);

  logic [MAX_NCH-1:0] pend_ext;

  assign pend_ext = MAX_NCH'(pend);
  assign any      = |pend;

`ifdef SIGNAL_MUX_ARB_RR_EN
  always_comb begin
    grant    = CHW'(rr_enc(pend_ext, IDXW'(rr_ptr), NCH));
    ptr_next = (grant == CHW'(NCH - 1)) ? '0 : grant + 1'b1;
  end
`else
  logic unused_rr_ptr;

  // Without round robin the pointer is pinned at zero and never consulted.
  always_comb begin
    grant         = CHW'(prio_enc(pend_ext));
    ptr_next      = '0;
    unused_rr_ptr = ^rr_ptr;
  end
`endif

endmodule

// File: rtl/signal_mux_arb.sv
// Registered request-tagged signal mux with per-channel capture slots.
// Arbitration mode selected by SIGNAL_MUX_ARB_RR_EN (see signal_mux_arb_sel).
module signal_mux_arb
  import signal_mux_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NCH   = 4,
  parameter int CHW   = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NCH-1:0]       req,
  input  logic [NCH*WIDTH-1:0] data_in,
  input  logic [WIDTH-1:0]     default_data,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  output logic [CHW-1:0]       out_ch,
  output logic [NCH-1:0]       overrun,
  input  logic                 overrun_clr
);

  logic [NCH-1:0]   pend_reg;
  logic [NCH-1:0]   overrun_reg;
  logic [WIDTH-1:0] slot_reg [NCH];
  logic [WIDTH-1:0] out_data_reg;
  logic             out_valid_reg;
  logic [CHW-1:0]   out_ch_reg;
  logic [CHW-1:0]   rr_ptr_reg;

  logic [CHW-1:0]   grant;
  logic [CHW-1:0]   ptr_next;
  logic             any_pend;
  logic             load;
  logic [NCH-1:0]   grant_hit;

  signal_mux_arb_sel #(
    .NCH (NCH),
    .CHW (CHW)
  ) u_sel (
    .pend     (pend_reg),
    .rr_ptr   (rr_ptr_reg),
    .grant    (grant),
    .any      (any_pend),
    .ptr_next (ptr_next)
  );

  assign load = (!out_valid_reg || out_ready) && any_pend;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_hit
    assign grant_hit[gi] = load && (grant == CHW'(gi));
  end

  // A req on the channel being granted refills the slot without counting as an overrun.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pend_reg    <= '0;
      overrun_reg <= '0;
      for (int k = 0; k < NCH; k++) slot_reg[k] <= '0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (req[k]) begin
          slot_reg[k] <= data_in[k*WIDTH +: WIDTH];
          pend_reg[k] <= 1'b1;
        end else if (grant_hit[k]) begin
          pend_reg[k] <= 1'b0;
        end
        if (overrun_clr) overrun_reg[k] <= 1'b0;
        else if (req[k] && pend_reg[k] && !grant_hit[k]) overrun_reg[k] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      out_ch_reg    <= '0;
      rr_ptr_reg    <= '0;
    end else if (load) begin
      out_data_reg  <= slot_reg[grant];
      out_ch_reg    <= grant;
      out_valid_reg <= 1'b1;
      rr_ptr_reg    <= ptr_next;
    end else if (!out_valid_reg || out_ready) begin
      // Idle or just drained: track the default word. Stalled words hold.
      out_data_reg  <= default_data;
      out_ch_reg    <= '0;
      out_valid_reg <= 1'b0;
    end
  end

  assign out_data  = out_data_reg;
  assign out_valid = out_valid_reg;
  assign out_ch    = out_ch_reg;
  assign overrun   = overrun_reg;

endmodule

// File: tb/tb_signal_mux_arb.sv
// Directed + randomized bench for signal_mux_arb, checked every cycle against a
// behavioural model (honours SIGNAL_MUX_ARB_RR_EN).
module tb_signal_mux_arb;

  localparam int WIDTH = 16;
  localparam int NCH   = 4;
  localparam int CHW   = 2;
`ifdef SIGNAL_MUX_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic [NCH-1:0]       req;
  logic [NCH*WIDTH-1:0] data_in;
  logic [WIDTH-1:0]     default_data;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_data;
  logic                 out_valid;
  logic [CHW-1:0]       out_ch;
  logic [NCH-1:0]       overrun;
  logic                 overrun_clr;

  int vectors     = 0;
  int miscompares = 0;

  // Behavioural model state
  bit          m_pend [NCH];
  logic [15:0] m_slot [NCH];
  logic [3:0]  m_ovr;
  logic        m_valid;
  logic [15:0] m_data;
  int          m_ch;
  int          m_ptr;

  always #5 clk = ~clk;

  signal_mux_arb #(.WIDTH(WIDTH), .NCH(NCH)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req          (req),
    .data_in      (data_in),
    .default_data (default_data),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ch       (out_ch),
    .overrun      (overrun),
    .overrun_clr  (overrun_clr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ch(input int k, input logic [15:0] v);
    data_in[k*WIDTH +: WIDTH] = v;
  endtask

  // One clock edge of the specification's rules, using the inputs present at the edge.
  task automatic model_step();
    bit          found;
    int          g;
    int          c;
    logic [15:0] gword;
    if (!reset_n) begin
      for (int k = 0; k < NCH; k++) begin m_pend[k] = 0; m_slot[k] = '0; end
      m_ovr = '0; m_valid = 0; m_data = '0; m_ch = 0; m_ptr = 0;
      return;
    end
    found = 0; g = 0;
    if (!m_valid || out_ready) begin
      for (int i = 0; i < NCH; i++) begin
        c = RR ? (m_ptr + i) % NCH : i;
        if (!found && m_pend[c]) begin found = 1; g = c; end
      end
    end
    gword = m_slot[g];
    for (int k = 0; k < NCH; k++) begin
      if (req[k]) begin
        if (m_pend[k] && !(found && g == k)) m_ovr[k] = 1'b1;
        m_slot[k] = data_in[k*WIDTH +: WIDTH];
        m_pend[k] = 1;
      end else if (found && g == k) begin
        m_pend[k] = 0;
      end
    end
    if (overrun_clr) m_ovr = '0;
    if (found) begin
      m_data = gword; m_ch = g; m_valid = 1;
      if (RR) m_ptr = (g + 1) % NCH;
    end else if (!m_valid || out_ready) begin
      m_data = default_data; m_ch = 0; m_valid = 0;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    chk("model_valid", 32'(out_valid), 32'(m_valid));
    chk("model_data", 32'(out_data), 32'(m_data));
    chk("model_ch", 32'(out_ch), 32'(m_ch));
    chk("model_overrun", 32'(overrun), 32'(m_ovr));
  endtask

  initial begin
    reset_n = 1'b0; req = '1; data_in = '0; default_data = 16'h00AA;
    out_ready = 1'b1; overrun_clr = 1'b0;
    for (int k = 0; k < NCH; k++) set_ch(k, 16'(32'hC0DE + k));

    // Reset with all requests asserted
    repeat (3) cycle();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    reset_n = 1'b1; req = '0;
    cycle();
    chk("idle_default", 32'(out_data), 32'h00AA);
    chk("idle_valid", 32'(out_valid), 32'd0);
    cycle();
    chk("no_pend_valid", 32'(out_valid), 32'd0);

    // Fixed priority: ch1 before ch3
    set_ch(1, 16'h1111); set_ch(3, 16'h3333); req = 4'b1010;
    cycle();
    req = '0;
    cycle();
    chk("prio_first_data", 32'(out_data), 32'h1111);
    chk("prio_first_ch", 32'(out_ch), 32'd1);
    cycle();
    chk("prio_second_data", 32'(out_data), 32'h3333);
    chk("prio_second_ch", 32'(out_ch), 32'd3);
    cycle();
    chk("prio_drain_valid", 32'(out_valid), 32'd0);
    chk("prio_drain_data", 32'(out_data), 32'h00AA);

    // Backpressure holds the word stable
    out_ready = 1'b0; set_ch(0, 16'h0BEE); req = 4'b0001;
    cycle();
    req = '0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_data", 32'(out_data), 32'h0BEE);
      chk("bp_ch", 32'(out_ch), 32'd0);
    end
    out_ready = 1'b1;
    cycle();
    chk("bp_accept_valid", 32'(out_valid), 32'd0);
    chk("bp_accept_data", 32'(out_data), 32'h00AA);

    // Simultaneous grant and capture on ch0
    set_ch(0, 16'h0001); req = 4'b0001;
    cycle();
    set_ch(0, 16'h0101);
    cycle();
    req = '0;
    chk("sim_old_data", 32'(out_data), 32'h0001);
    cycle();
    chk("sim_new_data", 32'(out_data), 32'h0101);
    chk("sim_no_overrun", 32'(overrun[0]), 32'd0);
    cycle();

    // Overrun on ch2 while the output is stalled on ch1
    out_ready = 1'b0; set_ch(1, 16'h1234); req = 4'b0010;
    cycle();
    req = '0;
    cycle();
    set_ch(2, 16'h0002); req = 4'b0100;
    cycle();
    set_ch(2, 16'h0022);
    cycle();
    req = '0;
    chk("ovr_set", 32'(overrun), 32'b0100);
    out_ready = 1'b1;
    cycle();
    chk("ovr_word", 32'(out_data), 32'h0022);
    chk("ovr_ch", 32'(out_ch), 32'd2);
    cycle();
    overrun_clr = 1'b1;
    cycle();
    overrun_clr = 1'b0;
    chk("ovr_cleared", 32'(overrun), 32'd0);

    // Clear wins over a same-cycle overrun set
    out_ready = 1'b0; set_ch(1, 16'h5555); req = 4'b0010;
    cycle();
    req = '0;
    cycle();
    req = 4'b0100;
    cycle();
    overrun_clr = 1'b1;
    cycle();
    req = '0; overrun_clr = 1'b0;
    chk("clr_priority", 32'(overrun), 32'd0);
    out_ready = 1'b1;
    repeat (3) cycle();

    // Continuous requests on all channels from a fresh reset
    reset_n = 1'b0;
    cycle();
    reset_n = 1'b1; req = '1;
    cycle();
    for (int i = 0; i < 8; i++) begin
      cycle();
      chk("cont_valid", 32'(out_valid), 32'd1);
      chk("cont_ch", 32'(out_ch), RR ? 32'(i % NCH) : 32'd0);
    end
    req = '0;
    repeat (5) cycle();

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      reset_n      = ($urandom_range(0, 99) != 0);
      req          = 4'($urandom_range(0, 3) == 0 ? $urandom : ($urandom & $urandom));
      data_in      = {$urandom, $urandom};
      default_data = 16'($urandom);
      out_ready    = ($urandom_range(0, 3) != 0);
      overrun_clr  = ($urandom_range(0, 15) == 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
